sram_array_ctrl: RTL

Storage stage directly downstream of the AHB SRAM bus interface. Consumes its `sram_cs` / `sram_we` / `sram_addr` / `ihwdata` strobes and returns `ihrdata`. It holds a 512 x 32 array behind a one-entry write-posting buffer with read-after-write forwarding. A post-reset zero-fill state machine clears the whole array before any bus access is accepted.

---
 rtl/sram_array_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/sram_array_ctrl.sv
// 512x32 storage behind a one-entry write-posting buffer with read forwarding; read data 1 cycle after strobe.
// No backpressure: accesses sampled during the post-reset zero-fill are dropped and flagged on err_access.
module sram_array_ctrl #(
    parameter int DW      = 32,
    parameter int AW      = 9,
    parameter int DEPTH   = 512,
    parameter bit INIT_EN = 1'b1
) (
    input  logic          hclk,
    input  logic          hresetn,
    input  logic          sram_cs,
    input  logic          sram_we,
    input  logic [AW-1:0] sram_addr,
    input  logic [DW-1:0] ihwdata,
    output logic [DW-1:0] ihrdata,
    output logic          init_busy,
    output logic          err_access
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] addr;
        logic [DW-1:0] dat;
    } wb_t;

    localparam state_t RST_STATE = INIT_EN ? ST_INIT : ST_RUN;

    state_t        state_q, state_d;
    logic [AW-1:0] icnt_q, icnt_d;
    wb_t           wb_q, wb_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [DW-1:0] mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdat;

    always_comb begin
        state_d   = state_q;
        icnt_d    = icnt_q;
        wb_d      = wb_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wb_q.addr;
        mem_wdat  = wb_q.dat;

        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = icnt_q;
                mem_wdat  = '0;
                icnt_d    = icnt_q + AW'(1);
                err_d     = sram_cs;
                if (icnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (sram_cs && sram_we) begin
                    // Committing the older entry frees the buffer for the new write.
                    mem_we = wb_q.vld;
                    wb_d   = '{vld: 1'b1, addr: sram_addr, dat: ihwdata};
                end else if (sram_cs) begin
                    // Array port is busy with the read, so the buffer stays put.
                    if (wb_q.vld && (wb_q.addr == sram_addr)) begin
                        rdata_d = wb_q.dat;
                    end else begin
                        rdata_d = mem_q[sram_addr];
                    end
                end else if (wb_q.vld) begin
                    mem_we   = 1'b1;
                    wb_d.vld = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= RST_STATE;
            icnt_q  <= '0;
            wb_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            wb_q    <= wb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; the zero-fill pass is what clears it.
    always_ff @(posedge hclk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdat;
        end
    end

    assign ihrdata    = rdata_q;
    assign init_busy  = (state_q == ST_INIT);
    assign err_access = err_q;

endmodule
